// File: rtl/act_lut_sched_pkg.sv
// Shared definitions for the activation-LUT scheduler.
//   state_t   : scheduler FSM states
//   *_DEF     : default widths. The interp() helper is built on DATA_W_DEF and FRAC_W_DEF.
//   interp()  : computes base + ((next - base) * frac >>> FRAC_W), truncated to DATA_W.
package act_lut_sched_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int FRAC_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    INTERP = 2'd2
  } state_t;

  // Linear interpolation between two adjacent LUT entries.
  // The difference of two signed values needs one extra bit.
  // The product needs that width plus FRAC_W.
  // The arithmetic shift rounds toward -inf. The result always lies
  // between base and next, so truncating back to DATA_W cannot overflow.
  function automatic logic [DATA_W_DEF-1:0] interp(
    input logic signed [DATA_W_DEF-1:0] base,
    input logic signed [DATA_W_DEF-1:0] next,
    input logic        [FRAC_W_DEF-1:0] frac
  );
    logic signed [DATA_W_DEF:0]            diff;
    logic signed [DATA_W_DEF+FRAC_W_DEF:0] d_ext;
    logic signed [DATA_W_DEF+FRAC_W_DEF:0] f_ext;
    logic signed [DATA_W_DEF+FRAC_W_DEF:0] prod;
    logic signed [DATA_W_DEF+FRAC_W_DEF:0] sh;
    diff  = {next[DATA_W_DEF-1], next} - {base[DATA_W_DEF-1], base};
    d_ext = {{FRAC_W_DEF{diff[DATA_W_DEF]}}, diff};
    f_ext = {{(DATA_W_DEF+1){1'b0}}, frac};
    prod  = d_ext * f_ext;
    sh    = prod >>> FRAC_W_DEF;
    return base + sh[DATA_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index of the last granted requester; the search starts at ptr+1 and wraps around
//   grant : one-hot grant (all zero when there is no request)
//   idx   : index of the granted requester
//   found : at least one request is set
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/act_lut_scheduler.sv
// Shares one combinational activation LUT among N_REQ requesters.
//   clk, rst            : clock and synchronous active-high reset
//   req, z_in           : per-requester request level and packed pre-activation
//   ack                 : one-hot, one-cycle pulse; the request has been captured
//   lut_addr            : registered address to the shared LUT
//   lut_base, lut_next  : LUT entry at lut_addr and the entry that follows it
//   res_valid/id/data   : one-cycle result strobe, requester index and activation
//   busy                : FSM is not in IDLE
//
// Handshake: a requester holds req[i] high, with z_in slice i stable, until
// it sees ack[i]. It drops req[i] in the next cycle.
// A req bit that is still high when the FSM returns to IDLE counts as a new request.
// req changes made while the FSM is busy are not looked at until IDLE.
module act_lut_scheduler
  import act_lut_sched_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*(ADDR_W+FRAC_W)-1:0] z_in,
  output logic [N_REQ-1:0]                 ack,
  output logic [ADDR_W-1:0]                lut_addr,
  input  logic [DATA_W-1:0]                lut_base,
  input  logic [DATA_W-1:0]                lut_next,
  output logic                             res_valid,
  output logic [$clog2(N_REQ)-1:0]         res_id,
  output logic [DATA_W-1:0]                res_data,
  output logic                             busy
);

  localparam int ZW    = ADDR_W + FRAC_W;
  localparam int IDX_W = $clog2(N_REQ);

  state_t state, state_n;

  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         id_q;
  logic [FRAC_W-1:0]        frac_q;
  logic signed [DATA_W-1:0] base_q;
  logic signed [DATA_W-1:0] next_q;

  logic [N_REQ-1:0] g_oh;
  logic [IDX_W-1:0] g_idx;
  logic             g_found;
  logic [ZW-1:0]    z_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (g_oh),
    .idx   (g_idx),
    .found (g_found)
  );

  always_comb begin
    z_sel = z_in[int'(g_idx)*ZW +: ZW];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (g_found) state_n = LOOKUP;
      LOOKUP:  state_n = INTERP;
      INTERP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      ack       <= '0;
      lut_addr  <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      id_q      <= '0;
      frac_q    <= '0;
      base_q    <= '0;
      next_q    <= '0;
    end else begin
      state     <= state_n;
      ack       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (g_found) begin
            // lut_addr keeps the integer part of z; only the fraction is stored.
            lut_addr <= z_sel[ZW-1:FRAC_W];
            frac_q   <= z_sel[FRAC_W-1:0];
            id_q     <= g_idx;
            ptr      <= g_idx;
            ack      <= g_oh;
          end
        end
        LOOKUP: begin
          base_q <= lut_base;
          next_q <= lut_next;
        end
        INTERP: begin
          res_data  <= interp(base_q, next_q, frac_q);
          res_id    <= id_q;
          res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
